abacus_wb_sampler: RTL
======================

Name: abacus_wb_sampler

Overview:
Wishbone master that sits directly upstream of the ABACUS profiler register file and drives its Wishbone slave port. On a periodic tick or an external trigger, it sweeps a contiguous window of counter registers and reads each one. Each read result is emitted as a beat on a valid/ready stream, which a trace/UART packetiser downstream consumes. This removes the need for the CPU to poll the profiler counters.

Parameters:
ABACUS_BASE_ADDR, 32'hf0030000, base address of the profiler register map
WINDOW_OFFSET, 16'h0200, offset of the first swept register (default: cache profile unit)
NUM_WORDS, 8, number of consecutive 32-bit registers per sweep (1..32)
PERIOD_WIDTH, 24, width of the period input
WB_TIMEOUT, 16, cycles to wait for wb_ack before abandoning a read

Ports:
clk  in  1  sole clock
rst  in  1  reset; asynchronous, active-low
enable  in  1  periodic sampling enable
period  in  PERIOD_WIDTH  tick interval in cycles; 0 = periodic ticks off (trigger only)
trigger  in  1  single-cycle sweep request
clr_status  in  1  clears the sticky overrun and timeout_err flags
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  Wishbone write enable; tied 0
wb_adr  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data; tied 0
wb_dat_i  in  32  Wishbone read data
wb_ack  in  1  Wishbone acknowledge
m_valid  out  1  stream beat valid
m_ready  in  1  stream beat accepted
m_data  out  32  sampled register value
m_index  out  5  word index within the window
m_last  out  1  final beat of a sweep
m_seq  out  8  sweep sequence number
busy  out  1  sweep in progress
overrun  out  1  sticky: a start request arrived while busy
timeout_err  out  1  sticky: a read timed out

Behaviour:
- Reset: all outputs go to 0 immediately while rst=0. Internal state: timer = period, idx = 0, seq = 0, state IDLE.
- States: IDLE, BUS, PUSH.
- Timer:
  - Decrements while enable=1 and period!=0.
  - Produces a tick when the count reaches 1, then reloads with period. Ticks therefore occur every period cycles.
  - While enable=0 or period=0, the timer holds at period.
- Start request: tick OR trigger.
  - In IDLE: enter BUS with idx = 0.
  - In BUS or PUSH: set overrun; the request is dropped.
  - A tick and a trigger in the same cycle start one sweep only.
- BUS state:
  - wb_cyc = wb_stb = 1.
  - wb_adr = ABACUS_BASE_ADDR + WINDOW_OFFSET + 4*idx.
  - On wb_ack: latch wb_dat_i into m_data and go to PUSH. cyc/stb are registered, so they are low in the following cycle.
  - Single-cycle-ack slaves therefore complete a read in 2 cycles from BUS entry.
  - If no ack within WB_TIMEOUT cycles of BUS entry: m_data = 32'hDEADBEEF, set timeout_err, go to PUSH.
- PUSH state:
  - m_valid = 1; m_index = idx; m_last = (idx == NUM_WORDS-1); m_seq = seq.
  - m_data, m_index, m_last and m_seq stay stable until m_ready.
  - No Wishbone activity occurs while in PUSH.
- On handshake (m_valid & m_ready):
  - If m_last: go to IDLE and increment seq (mod 256; 255 wraps to 0).
  - Otherwise: idx += 1 and return to BUS.
- Dropping enable mid-sweep does not abort the sweep; the sweep completes.
- busy = (state != IDLE).
- Sticky flags: clr_status clears overrun and timeout_err. If a set and clr_status occur in the same cycle, the set wins.
- Reset mid-sweep: wb_cyc/wb_stb drop asynchronously and the partial sweep is discarded with no beat emitted.
- Address arithmetic is 32-bit unsigned with wrap; the index field is zero-extended to 5 bits.

Decomposition:
- Package abacus_pkg holds:
  - ABACUS_BASE_ADDR default
  - unit offsets (16'h0100 instruction, 16'h0200 cache)
  - the sampler_state_t enum {IDLE, BUS, PUSH}
  - the TIMEOUT_SENTINEL constant 32'hDEADBEEF
- Sub-module abacus_sample_timer: a period down-counter with reload that outputs the tick.

Test Plan:
1. Hold rst=0 mid-cycle -> every output reads 0 immediately; after release, no Wishbone activity until a start request.
2. Slave model with single-cycle ack returning 0x11,0x22..0x88; period=100, enable=1, m_ready=1 ->
   - first sweep starts 100 cycles after enable;
   - 8 beats at addresses f0030200..f003021C with index 0..7 and matching data;
   - m_last only on index 7; seq=0;
   - next sweep at cycle 200 with seq=1.
3. m_ready held low for 5 cycles on beat 3 -> m_valid/m_data/m_index stable for all 5 cycles and wb_cyc stays 0; the sweep then resumes at index 4.
4. trigger pulsed during a sweep -> overrun=1 and exactly 8 beats are emitted; clr_status -> overrun=0; trigger in IDLE -> a new sweep starts.
5. Slave withholds ack for index 2 -> after 16 cycles a beat with m_data=DEADBEEF, m_index=2, timeout_err=1; index 3 is then read normally.
6. seq at 255 after a completed sweep -> the next sweep reports m_seq=0.

Source files
------------

// File: rtl/abacus_pkg.sv
// Shared constants and types for the ABACUS profiler sampler.
package abacus_pkg;

    localparam logic [31:0] ABACUS_BASE_ADDR_DEF = 32'hf0030000;

    // Profiler unit offsets within the ABACUS register map
    localparam logic [15:0] UNIT_OFS_INSTR = 16'h0100;
    localparam logic [15:0] UNIT_OFS_CACHE = 16'h0200;

    // Read data reported when the slave never acknowledges
    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        PUSH
    } sampler_state_t;

    // Byte address of word idx inside the swept window (32-bit wrap)
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] ofs,
                                              input logic [4:0]  idx);
        return base + {16'b0, ofs} + {25'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/abacus_sample_timer.sv
// Period down-counter: emits a one-cycle tick every 'period' cycles while
// enabled; holds at 'period' while disabled or when period is 0.
module abacus_sample_timer #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);

    // A stored count of 0 stands for "full period": this lets reset and
    // reload go to a constant instead of asynchronously loading a port.
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cur;
    logic                    run;

    assign run  = enable && (period != '0);
    assign cur  = (cnt == '0) ? period : cnt;
    assign tick = run && (cur == PERIOD_WIDTH'(1));

    // Count down while running; reload (back to "full period") on tick or stop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cur - 1'b1;
    end

endmodule

// File: rtl/abacus_wb_sampler.sv
// Wishbone master that periodically sweeps a window of ABACUS profiler
// counters and streams each read value as a valid/ready beat.
module abacus_wb_sampler
    import abacus_pkg::*;
#(
    parameter logic [31:0] ABACUS_BASE_ADDR = ABACUS_BASE_ADDR_DEF,
    parameter logic [15:0] WINDOW_OFFSET    = UNIT_OFS_CACHE,
    parameter int          NUM_WORDS        = 8,
    parameter int          PERIOD_WIDTH     = 24,
    parameter int          WB_TIMEOUT       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    trigger,
    input  logic                    clr_status,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [31:0]             wb_adr,
    output logic [31:0]             wb_dat_o,
    input  logic [31:0]             wb_dat_i,
    input  logic                    wb_ack,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_data,
    output logic [4:0]              m_index,
    output logic                    m_last,
    output logic [7:0]              m_seq,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int          TW       = $clog2(WB_TIMEOUT) + 1;
    localparam logic [4:0]  LAST_IDX = 5'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(WB_TIMEOUT - 1);

    sampler_state_t state, state_nxt;
    logic [4:0]     idx;
    logic [7:0]     seq;
    logic [TW-1:0]  wcnt;
    logic [31:0]    data_q;
    logic           overrun_q;
    logic           tmo_q;
    logic           tick;
    logic           start;
    logic           is_last;
    logic           tmo_hit;

    abacus_sample_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .period (period),
        .tick   (tick)
    );

    // Tick and trigger together still form a single request
    assign start   = tick | trigger;
    assign is_last = (idx == LAST_IDX);
    // Ack on the final allowed cycle still counts as a good read
    assign tmo_hit = (state == BUS) && !wb_ack && (wcnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: sweep IDLE -> (BUS -> PUSH)* -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUS;
            BUS:  if (wb_ack || tmo_hit) state_nxt = PUSH;
            PUSH: if (m_ready) state_nxt = is_last ? IDLE : BUS;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word index, sequence number, ack timeout and captured data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            seq    <= '0;
            wcnt   <= '0;
            data_q <= '0;
        end else begin
            // wcnt counts cycles spent in the current BUS visit, 0 elsewhere
            wcnt <= (state == BUS && state_nxt == BUS) ? wcnt + 1'b1 : '0;
            case (state)
                IDLE: if (start) idx <= '0;
                BUS: begin
                    if (wb_ack)
                        data_q <= wb_dat_i;
                    else if (tmo_hit)
                        data_q <= TIMEOUT_SENTINEL;
                end
                PUSH: begin
                    if (m_ready) begin
                        if (is_last)
                            seq <= seq + 8'd1;
                        else
                            idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky status; a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            overrun_q <= (start && state != IDLE) | (overrun_q & ~clr_status);
            tmo_q     <= tmo_hit | (tmo_q & ~clr_status);
        end
    end

    assign wb_cyc      = (state == BUS);
    assign wb_stb      = (state == BUS);
    assign wb_we       = 1'b0;
    assign wb_dat_o    = '0;
    assign wb_adr      = (state == BUS) ? word_addr(ABACUS_BASE_ADDR, WINDOW_OFFSET, idx) : '0;
    assign m_valid     = (state == PUSH);
    assign m_data      = data_q;
    assign m_index     = idx;
    assign m_last      = (state == PUSH) && is_last;
    assign m_seq       = seq;
    assign busy        = (state != IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = tmo_q;

endmodule
